bit_serial_alu: RTL

- Multi-cycle ALU that computes a WIDTH-bit ADD/SUB/AND/OR/XOR one bit per clock, LSB first, through a single 1-bit ALU slice.
- Synthesizable, sequential counterpart of the slice stimulus driver: it sequences operands, carry and sub-mode into the slice and collects the outputs.
- Sits beside the EX stage as a small-area execution option and as the first multi-bit consumer of the 1-bit slice.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_slice.sv | 24 ++
 rtl/bit_serial_alu.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: operation codes and sequencer states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } aluOp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aluState_e;

endpackage

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU slice: full adder with optional B inversion plus bitwise ops.
module alu_slice (
    input  logic a,
    input  logic b,
    input  logic sub_mode,
    input  logic carry_in,
    output logic add_out,
    output logic and_out,
    output logic or_out,
    output logic xor_out,
    output logic carry_out
);

    logic bEff;

    // Subtraction is A + ~B + 1; the +1 arrives through carry_in on the LSB.
    assign bEff      = b ^ sub_mode;
    assign add_out   = a ^ bEff ^ carry_in;
    assign carry_out = (a & bEff) | (carry_in & (a ^ bEff));
    assign and_out   = a & b;
    assign or_out    = a | b;
    assign xor_out   = a ^ b;

endmodule

// File: rtl/bit_serial_alu.sv
// Multi-cycle ALU: feeds one operand bit per clock, LSB first, through a single alu_slice.
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    aluState_e        state, stateNext;
    logic [CNT_W-1:0] bitCnt;
    logic [WIDTH-1:0] aSr, bSr, resultSr;
    logic [2:0]       opReg;
    logic             carry;

    logic             subMode, isArith, lastBit, accept;
    logic             sliceAdd, sliceAnd, sliceOr, sliceXor, sliceCarry;
    logic             selBit;
    logic [WIDTH-1:0] resultNext;

    assign subMode    = (opReg == OP_SUB);
    assign isArith    = (opReg == OP_ADD) || (opReg == OP_SUB);
    assign lastBit    = (state == ST_RUN) && (bitCnt == CNT_W'(WIDTH - 1));
    assign accept     = start && (state != ST_RUN);
    assign resultNext = {selBit, resultSr[WIDTH-1:1]};

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    alu_slice uSlice (
        .a        (aSr[0]),
        .b        (bSr[0]),
        .sub_mode (subMode),
        .carry_in (carry),
        .add_out  (sliceAdd),
        .and_out  (sliceAnd),
        .or_out   (sliceOr),
        .xor_out  (sliceXor),
        .carry_out(sliceCarry)
    );

    always_comb begin
        selBit = 1'b0;
        case (opReg)
            OP_ADD, OP_SUB: selBit = sliceAdd;
            OP_AND:         selBit = sliceAnd;
            OP_OR:          selBit = sliceOr;
            OP_XOR:         selBit = sliceXor;
            default:        selBit = 1'b0;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (start) stateNext = ST_RUN;
            ST_RUN:  if (lastBit) stateNext = ST_DONE;
            ST_DONE: stateNext = start ? ST_RUN : ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // Control and visible outputs; results are registered on the last bit so they are valid while done is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bitCnt    <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
        end else begin
            state <= stateNext;
            if (accept) begin
                bitCnt <= '0;
            end else if (state == ST_RUN) begin
                bitCnt <= bitCnt + CNT_W'(1);
            end
            if (lastBit) begin
                result    <= resultNext;
                carry_out <= isArith & sliceCarry;
                // carry still holds the carry into the MSB during the last bit.
                overflow  <= isArith & (carry ^ sliceCarry);
                zero      <= (resultNext == '0);
            end
        end
    end

    // Operand and partial-result shift registers; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            aSr      <= a;
            bSr      <= b;
            opReg    <= op;
            carry    <= (op == OP_SUB);
            resultSr <= '0;
        end else if (state == ST_RUN) begin
            aSr      <= {1'b0, aSr[WIDTH-1:1]};
            bSr      <= {1'b0, bSr[WIDTH-1:1]};
            resultSr <= resultNext;
            carry    <= sliceCarry;
        end
    end

endmodule
